// File: rtl/ahbl_narrow_bridge.sv
// AHB-Lite 32-bit slave to 16-bit AHB-Lite master bridge.
// Word accesses become two halfword beats (NONSEQ low, SEQ high). Byte and
// halfword accesses pass straight through as a single beat. The second beat's
// address phase overlaps the first beat's data phase, so a word costs the
// upstream master one extra cycle when the downstream slave has no wait states.
module ahbl_narrow_bridge #(
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // upstream (32-bit slave side)
    output logic              s_hready_resp,
    input  logic              s_hready,
    output logic              s_hresp,
    input  logic [W_ADDR-1:0] s_haddr,
    input  logic              s_hwrite,
    input  logic [1:0]        s_htrans,
    input  logic [2:0]        s_hsize,
    input  logic [2:0]        s_hburst,
    input  logic [3:0]        s_hprot,
    input  logic              s_hmastlock,
    input  logic [31:0]       s_hwdata,
    output logic [31:0]       s_hrdata,
    // downstream (16-bit master side)
    input  logic              m_hready_resp,
    input  logic              m_hresp,
    output logic [W_ADDR-1:0] m_haddr,
    output logic              m_hwrite,
    output logic [1:0]        m_htrans,
    output logic [2:0]        m_hsize,
    output logic [2:0]        m_hburst,
    output logic [3:0]        m_hprot,
    output logic              m_hmastlock,
    output logic [15:0]       m_hwdata,
    input  logic [15:0]       m_hrdata
);

    // State names the data phase currently in flight downstream.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NARROW = 2'd1,
        ST_W0     = 2'd2,
        ST_W1     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [W_ADDR-1:2]   r_addr;     // word address of the access being split
    logic                r_write;
    logic [3:0]          r_prot;
    logic                r_a1;       // halfword lane of the current narrow access
    logic [15:0]         r_lo;       // low halfword of a word read

    logic                w_req;
    logic                w_word;
    logic                w_accept;
    logic                w_unused;

    assign w_req    = s_hready && s_htrans[1];
    assign w_word   = (s_hsize == 3'd2);
    // A new upstream request is taken whenever the bridge is not issuing its own beat.
    assign w_accept = m_hready_resp && (r_state != ST_W0) && w_req;

    // Downstream slaves here only ever answer OKAY; burst and lock are not forwarded.
    assign w_unused    = ^{s_hburst, s_hmastlock, m_hresp};
    assign s_hresp     = 1'b0;
    assign m_hburst    = 3'b000;
    assign m_hmastlock = 1'b0;

    // State register; reset drops any half-finished word without issuing beat 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Capture the request on its accepting edge and the low read halfword at end of W0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_prot  <= 4'h0;
            r_a1    <= 1'b0;
            r_lo    <= 16'h0;
        end else begin
            if (w_accept) begin
                r_addr  <= s_haddr[W_ADDR-1:2];
                r_write <= s_hwrite;
                r_prot  <= s_hprot;
                r_a1    <= s_haddr[1];
            end
            if (r_state == ST_W0 && m_hready_resp) r_lo <= m_hrdata;
        end
    end

    // Next state plus all downstream address/data and upstream response muxing.
    always_comb begin
        w_state_nx    = r_state;
        m_htrans      = s_htrans & {2{s_hready}};
        m_haddr       = s_haddr;
        m_hsize       = s_hsize;
        m_hwrite      = s_hwrite;
        m_hprot       = s_hprot;
        m_hwdata      = r_a1 ? s_hwdata[31:16] : s_hwdata[15:0];
        s_hrdata      = {m_hrdata, m_hrdata};
        s_hready_resp = m_hready_resp;

        if (r_state == ST_W0) begin
            // Bridge-generated high beat; upstream is held off for this cycle.
            m_htrans      = 2'b11;
            m_haddr       = {r_addr, 2'b10};
            m_hsize       = 3'd1;
            m_hwrite      = r_write;
            m_hprot       = r_prot;
            m_hwdata      = s_hwdata[15:0];
            s_hready_resp = 1'b0;
            if (m_hready_resp) w_state_nx = ST_W1;
        end else begin
            if (w_req && w_word) begin
                m_htrans = 2'b10;
                m_haddr  = {s_haddr[W_ADDR-1:2], 2'b00};
                m_hsize  = 3'd1;
            end
            if (r_state == ST_W1) begin
                m_hwdata = s_hwdata[31:16];
                s_hrdata = {m_hrdata, r_lo};
            end
            if (m_hready_resp) begin
                if (!w_req)      w_state_nx = ST_IDLE;
                else if (w_word) w_state_nx = ST_W0;
                else             w_state_nx = ST_NARROW;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_narrow_bridge.sv
// Bench for ahbl_narrow_bridge: pipelined upstream master, wait-state capable
// downstream slave, and a beat scoreboard filled when upstream ops are queued.
module tb_ahbl_narrow_bridge;

    logic        clk;
    logic        rst_n;
    logic        s_hready_resp, s_hready, s_hresp;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;
    logic        s_hmastlock;
    logic [31:0] s_hwdata, s_hrdata;
    logic        m_hready_resp, m_hresp;
    logic [31:0] m_haddr;
    logic        m_hwrite;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize, m_hburst;
    logic [3:0]  m_hprot;
    logic        m_hmastlock;
    logic [15:0] m_hwdata, m_hrdata;

    ahbl_narrow_bridge #(.W_ADDR(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_hready_resp(s_hready_resp), .s_hready(s_hready), .s_hresp(s_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot),
        .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
        .m_hready_resp(m_hready_resp), .m_hresp(m_hresp), .m_haddr(m_haddr),
        .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock),
        .m_hwdata(m_hwdata), .m_hrdata(m_hrdata)
    );

    localparam logic [3:0] PROT = 4'hA;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall;
    } up_op_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        write;
        logic [15:0] wdata;
    } beat_t;

    up_op_t      ops[$];
    beat_t       bq[$];
    logic [15:0] rdq[$];

    int   checks = 0;
    int   errors = 0;
    int   sl_waits = 0;
    logic ext_stall = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-slave upstream bus unless another slave is modelled as stalling.
    assign s_hready = ext_stall ? 1'b0 : s_hready_resp;
    assign m_hresp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Queue an upstream op and the downstream beats it must produce.
    function automatic void push_op(input logic [31:0] a, input logic [2:0] sz, input logic w,
                                    input logic [31:0] wd, input logic [31:0] rd, input int st);
        up_op_t o;
        beat_t  b;
        o.addr = a; o.size = sz; o.write = w; o.wdata = wd; o.rdata = rd; o.stall = st;
        ops.push_back(o);
        if (sz == 3'd2) begin
            b.addr = {a[31:2], 2'b00}; b.size = 3'd1; b.trans = 2'b10; b.write = w; b.wdata = wd[15:0];
            bq.push_back(b);
            b.addr = {a[31:2], 2'b10}; b.trans = 2'b11; b.wdata = wd[31:16];
            bq.push_back(b);
        end else begin
            b.addr = a; b.size = sz; b.trans = 2'b10; b.write = w;
            b.wdata = a[1] ? wd[31:16] : wd[15:0];
            bq.push_back(b);
        end
    endfunction

    // Downstream slave: decisions sampled at negedge, applied at posedge.
    logic        sl_dp, nx_dp, sl_dpw, nx_dpw;
    int          sl_cnt, nx_cnt;
    logic [15:0] sl_expw, nx_expw, sl_rd, nx_rd;
    logic        hold_v;
    logic [31:0] hold_a;

    assign m_hready_resp = !sl_dp || (sl_cnt == 0);
    assign m_hrdata      = sl_rd;

    always @(negedge clk) begin
        if (rst_n) begin
            nx_dp   <= sl_dp;
            nx_dpw  <= sl_dpw;
            nx_expw <= sl_expw;
            nx_rd   <= sl_rd;
            nx_cnt  <= (sl_dp && sl_cnt > 0) ? sl_cnt - 1 : sl_cnt;
            if (m_hready_resp) begin
                if (sl_dp && sl_dpw) chk("wdata", 32'(m_hwdata), 32'(sl_expw));
                nx_dp <= 1'b0;
                if (m_htrans[1]) begin
                    nx_dp  <= 1'b1;
                    nx_cnt <= sl_waits;
                    nx_dpw <= m_hwrite;
                    if (bq.size() == 0) chk("beat_unexp", m_haddr, 32'hFFFF_FFFF);
                    else begin
                        chk("baddr",  m_haddr, bq[0].addr);
                        chk("bsize",  32'(m_hsize), 32'(bq[0].size));
                        chk("btrans", 32'(m_htrans), 32'(bq[0].trans));
                        chk("bwrite", 32'(m_hwrite), 32'(bq[0].write));
                        chk("bprot",  32'(m_hprot), 32'(PROT));
                        nx_expw <= bq[0].wdata;
                        void'(bq.pop_front());
                    end
                    if (!m_hwrite) nx_rd <= (rdq.size() > 0) ? rdq.pop_front() : 16'hDEAD;
                end
            end
            if (!m_hready_resp && m_htrans[1]) begin
                if (hold_v) chk("addr_hold", m_haddr, hold_a);
                hold_a <= m_haddr;
                hold_v <= 1'b1;
            end else hold_v <= 1'b0;
        end else hold_v <= 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_dp <= 1'b0; sl_cnt <= 0; sl_dpw <= 1'b0; sl_expw <= 16'h0; sl_rd <= 16'h0;
        end else begin
            sl_dp <= nx_dp; sl_cnt <= nx_cnt; sl_dpw <= nx_dpw; sl_expw <= nx_expw; sl_rd <= nx_rd;
        end
    end

    // Pipelined upstream master: runs until all queued ops finish their data phase.
    task automatic run_ops();
        up_op_t dp;
        logic   dpv = 1'b0;
        logic   rdy;
        int     st = 0;
        int     cyc = 0;
        while ((ops.size() > 0 || dpv) && cyc < 300) begin
            if (ops.size() > 0) begin
                s_haddr  = ops[0].addr;
                s_hsize  = ops[0].size;
                s_hwrite = ops[0].write;
                s_htrans = 2'b10;
            end else s_htrans = 2'b00;
            s_hwdata = dpv ? dp.wdata : 32'h0;
            @(negedge clk);
            rdy = s_hready_resp;
            if (dpv) begin
                if (!rdy) st++;
                else begin
                    if (!dp.write) chk("rdata", s_hrdata, dp.rdata);
                    chk("stall", st, dp.stall);
                    dpv = 1'b0;
                    st  = 0;
                end
            end
            if (rdy && ops.size() > 0) begin
                dp  = ops.pop_front();
                dpv = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_htrans = 2'b00;
        if (cyc >= 300) chk("timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        s_haddr = 32'h0; s_hwrite = 1'b0; s_htrans = 2'b00; s_hsize = 3'd0;
        s_hburst = 3'd0; s_hprot = PROT; s_hmastlock = 1'b0; s_hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",    32'(s_hready_resp), 32'd1);
        chk("rst_htrans", 32'(m_htrans), 32'd0);
        chk("rst_hresp",  32'(s_hresp), 32'd0);
        chk("rst_hburst", 32'(m_hburst), 32'd0);
        chk("rst_mlock",  32'(m_hmastlock), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // word write, zero-wait
        sl_waits = 0;
        push_op(32'h100, 3'd2, 1'b1, 32'hDEAD_BEEF, 32'h0, 1);
        run_ops();

        // word read
        rdq.push_back(16'h5678); rdq.push_back(16'h1234);
        push_op(32'h204, 3'd2, 1'b0, 32'h0, 32'h1234_5678, 1);
        run_ops();

        // byte write then halfword read, back to back
        rdq.push_back(16'hC0DE);
        push_op(32'h003, 3'd0, 1'b1, 32'hAB00_0000, 32'h0, 0);
        push_op(32'h002, 3'd1, 1'b0, 32'h0, 32'hC0DE_C0DE, 0);
        run_ops();

        // word read then byte read with two wait states per beat
        sl_waits = 2;
        rdq.push_back(16'h1111); rdq.push_back(16'h2222); rdq.push_back(16'h0033);
        push_op(32'h000, 3'd2, 1'b0, 32'h0, 32'h2222_1111, 5);
        push_op(32'h009, 3'd0, 1'b0, 32'h0, 32'h0033_0033, 2);
        run_ops();
        sl_waits = 0;

        // valid address phase while another slave holds hready low
        ext_stall = 1'b1;
        s_haddr = 32'h40; s_hsize = 3'd2; s_hwrite = 1'b1; s_htrans = 2'b10;
        #1;
        chk("xstall_htrans", 32'(m_htrans), 32'd0);
        @(posedge clk); #1;
        s_htrans = 2'b00; ext_stall = 1'b0;
        chk("xstall_rdy", 32'(s_hready_resp), 32'd1);
        @(posedge clk); #1;

        // reset asserted during W0 of a word write
        begin
            beat_t b;
            b.addr = 32'h300; b.size = 3'd1; b.trans = 2'b10; b.write = 1'b1; b.wdata = 16'h2222;
            bq.push_back(b);
        end
        s_haddr = 32'h300; s_hsize = 3'd2; s_hwrite = 1'b1; s_htrans = 2'b10;
        @(posedge clk); #1;
        s_htrans = 2'b00; s_hwdata = 32'h1111_2222;
        chk("w0_rdy",    32'(s_hready_resp), 32'd0);
        chk("w0_htrans", 32'(m_htrans), 32'd3);
        chk("w0_addr",   m_haddr, 32'h302);
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy",    32'(s_hready_resp), 32'd1);
        chk("mrst_htrans", 32'(m_htrans), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_bq", 32'(bq.size()), 32'd0);
        @(posedge clk); #1;

        // first transfer after reset
        push_op(32'h400, 3'd2, 1'b1, 32'hCAFE_F00D, 32'h0, 1);
        run_ops();
        @(posedge clk); #1;

        chk("end_bq",  32'(bq.size()), 32'd0);
        chk("end_rdq", 32'(rdq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbl_narrow_bridge.md
Name: ahbl_narrow_bridge

Overview:
- AHB-Lite 32-bit slave to 16-bit AHB-Lite master bridge, placed directly upstream of the 16-bit async SRAM controller.
- A 32-bit word access is split into two halfword beats; byte and halfword accesses pass through as single beats.
- Fully pipelined: downstream address phases overlap upstream data phases, so no bubble is added between transfers.
- Upstream stalls exactly one extra cycle per word access when the downstream slave is zero-wait.

Parameters:
W_ADDR, 32, address width on both ports.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_hready_resp  output  1  upstream slave ready response
s_hready  input  1  upstream bus hready
s_hresp  output  1  tied 0
s_haddr  input  W_ADDR  upstream address
s_hwrite  input  1  upstream write
s_htrans  input  2  upstream transfer type
s_hsize  input  3  upstream size (0/1/2 only)
s_hburst  input  3  ignored
s_hprot  input  4  protection
s_hmastlock  input  1  ignored
s_hwdata  input  32  upstream write data
s_hrdata  output  32  upstream read data
m_hready_resp  input  1  downstream slave ready; also the downstream slave's hready
m_hresp  input  1  unused; downstream slaves in this subsystem are OKAY-only
m_haddr  output  W_ADDR  downstream address
m_hwrite  output  1  downstream write
m_htrans  output  2  downstream transfer type
m_hsize  output  3  downstream size
m_hburst  output  3  tied 0 (SINGLE)
m_hprot  output  4  protection
m_hmastlock  output  1  tied 0
m_hwdata  output  16  downstream write data
m_hrdata  input  16  downstream read data

Behaviour:
- Upstream request is valid when s_hready && s_htrans[1]. Upstream request fields drive downstream combinationally, with m_htrans = s_htrans & {2{s_hready}}.
- States and state changes (all gated by m_hready_resp = 1):
  - IDLE: no data phase in progress. Goes to NARROW on a valid non-word request, to W0 on a valid word request, otherwise stays in IDLE.
  - NARROW: data phase of a single beat. Goes to NARROW, W0 or IDLE according to the new request.
  - W0: data phase of the low halfword beat. Always goes to W1.
  - W1: data phase of the high halfword beat. Goes to NARROW, W0 or IDLE according to the new request.
- Address-phase drive in IDLE/NARROW/W1 (pass-through):
  - Non-word request: m_haddr = s_haddr, m_hsize = s_hsize.
  - Word request: m_haddr = s_haddr & ~3, m_hsize = 1, m_htrans = NONSEQ.
  - m_hwrite = s_hwrite, m_hprot = s_hprot.
  - On the accepting edge, latch word address, hwrite, hprot and addr[1].
- Address-phase drive in W0 (internal second beat): m_htrans = SEQ (2'b11), m_haddr = latched word address | 2, m_hsize = 1, m_hwrite and m_hprot from latches. The upstream next request is not forwarded.
- s_hready_resp: 0 in W0; m_hready_resp in all other states. IDLE gives 1.
- Write data:
  - W0: m_hwdata = s_hwdata[15:0].
  - W1: m_hwdata = s_hwdata[31:16].
  - NARROW: latched addr[1] ? s_hwdata[31:16] : s_hwdata[15:0].
  - s_hwdata is stable throughout, since upstream is stalled in W0.
- Read data:
  - At the end of W0 (m_hready_resp = 1), capture m_hrdata into a 16-bit lo register.
  - W1: s_hrdata = {m_hrdata, lo}.
  - NARROW/IDLE: s_hrdata = {m_hrdata, m_hrdata}, giving correct lane placement for bytes and halfwords.
- Downstream wait states: hold the current state; hold internal beat address and control.
- Reset mid-word: return to IDLE immediately. Beat 1 is not issued.
- Reset values: state IDLE; latches 0; lo 0.
  - Resulting outputs: s_hready_resp = m_hready_resp, which is 1 with an idle slave. m_htrans follows the masked s_htrans, which is 0 with an idle master. s_hresp, m_hburst and m_hmastlock are 0.

Test Plan:
- Word write 0xDEADBEEF @0x100, zero-wait downstream -> beats 0x100 NONSEQ size1 hwdata 0xBEEF, then 0x102 SEQ size1 hwdata 0xDEAD; s_hready_resp low exactly 1 cycle.
- Word read @0x204, downstream returns 0x5678 then 0x1234 -> s_hrdata = 0x12345678 in the cycle s_hready_resp rises.
- Byte write 0xAB @0x003 (hwdata 0xAB000000), then halfword read @0x002 -> single beats; m_hwdata 0xAB00 at addr 0x003; read data appears in s_hrdata[31:16]; no stall.
- Back-to-back word read @0x0 then byte read @0x9 with 2 downstream wait states on each beat -> addresses 0x0, 0x2, 0x9 in order; each address held stable across waits; upstream sees 5 stall cycles on the word.
- Valid address phase with s_hready = 0 (another slave stalling) -> m_htrans = IDLE; no beat issued.
- rst_n asserted during W0 of a word write -> state IDLE, no 0x…2 beat issued; first post-reset transfer behaves normally.
